// File: rtl/flag_unit.sv
// flag_unit: processor flag register sitting behind rom_alu.
//
// Holds the link bit L and the N, Z and V flags, and produces a
// registered active-low skip request for the sequencer.
//
// Ports:
//   clk5          sole clock, rising edge
//   reset         asynchronous, active-low reset
//   y             ALU result
//   a15, b15      sign bits of ALU operands A and B (overflow detect)
//   alu_l_toggle  ALU carry-out / new L value
//   alu_l_latch   active-low: load L from alu_l_toggle this edge
//   flagop        microcode flag operation (see flagop_e)
//   ibus_in       ibus value for flag restore (WRF)
//   ibus_out      flag word, zero when not driving
//   ibus_oe       active-low ibus drive enable (RDF)
//   cond_en       evaluate skip condition this edge
//   cond_mask     selects {N,Z,V,L} terms of the condition
//   cond_inv      inverts the condition result
//   l, fn, fz, fv registered link / negative / zero / overflow flags
//   skip          active-low registered skip request
module flag_unit #(
    parameter int WIDTH    = 16,
    parameter int FLAG_MSB = 15
) (
    input  logic             clk5,
    input  logic             reset,
    input  logic [WIDTH-1:0] y,
    input  logic             a15,
    input  logic             b15,
    input  logic             alu_l_toggle,
    input  logic             alu_l_latch,
    input  logic [2:0]       flagop,
    input  logic [WIDTH-1:0] ibus_in,
    output logic [WIDTH-1:0] ibus_out,
    output logic             ibus_oe,
    input  logic             cond_en,
    input  logic [3:0]       cond_mask,
    input  logic             cond_inv,
    output logic             l,
    output logic             fn,
    output logic             fz,
    output logic             fv,
    output logic             skip
);

    typedef enum logic [2:0] {
        OP_IDLE = 3'b000,
        OP_UPD  = 3'b001,
        OP_CLL  = 3'b010,
        OP_STL  = 3'b011,
        OP_CML  = 3'b100,
        OP_WRF  = 3'b101,
        OP_RDF  = 3'b110,
        OP_RSV  = 3'b111
    } flagop_e;

    flagop_e op;
    logic    l_nxt, fn_nxt, fz_nxt, fv_nxt, skip_nxt;
    logic    cond_hit;
    logic    rdf;
    logic [WIDTH-1:0] flag_word;

    assign op = flagop_e'(flagop);

    always_comb begin
        l_nxt  = l;
        fn_nxt = fn;
        fz_nxt = fz;
        fv_nxt = fv;

        // The ALU carry load is the fallback; explicit L ops below override it.
        if (!alu_l_latch) begin
            l_nxt = alu_l_toggle;
        end

        case (op)
            OP_UPD: begin
                fn_nxt = y[WIDTH-1];
                fz_nxt = (y == '0);
                fv_nxt = (a15 == b15) && (y[WIDTH-1] != a15);
            end
            OP_CLL: l_nxt = 1'b0;
            OP_STL: l_nxt = 1'b1;
            OP_CML: l_nxt = ~l;
            OP_WRF: begin
                fn_nxt = ibus_in[FLAG_MSB];
                l_nxt  = ibus_in[FLAG_MSB-1];
                fz_nxt = ibus_in[FLAG_MSB-2];
                fv_nxt = ibus_in[FLAG_MSB-3];
            end
            default: ;
        endcase
    end

    // Condition uses pre-edge flags; skip is active-low so a hit drives it 0.
    assign cond_hit = |(cond_mask & {fn, fz, fv, l});

    always_comb begin
        skip_nxt = skip;
        if (cond_en) begin
            skip_nxt = ~(cond_hit ^ cond_inv);
        end
    end

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            l    <= 1'b0;
            fn   <= 1'b0;
            fz   <= 1'b0;
            fv   <= 1'b0;
            skip <= 1'b1;
        end else begin
            l    <= l_nxt;
            fn   <= fn_nxt;
            fz   <= fz_nxt;
            fv   <= fv_nxt;
            skip <= skip_nxt;
        end
    end

    always_comb begin
        flag_word               = '0;
        flag_word[FLAG_MSB]     = fn;
        flag_word[FLAG_MSB-1]   = l;
        flag_word[FLAG_MSB-2]   = fz;
        flag_word[FLAG_MSB-3]   = fv;
    end

    // Bus is released during reset even if RDF is presented.
    assign rdf      = (op == OP_RDF) && reset;
    assign ibus_oe  = ~rdf;
    assign ibus_out = rdf ? flag_word : '0;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

    logic        clk5 = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] y = '0;
    logic        a15 = 1'b0, b15 = 1'b0;
    logic        alu_l_toggle = 1'b0, alu_l_latch = 1'b1;
    logic [2:0]  flagop = 3'b000;
    logic [15:0] ibus_in = '0;
    logic [15:0] ibus_out;
    logic        ibus_oe;
    logic        cond_en = 1'b0;
    logic [3:0]  cond_mask = '0;
    logic        cond_inv = 1'b0;
    logic        l, fn, fz, fv, skip;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic m_l = 0, m_fn = 0, m_fz = 0, m_fv = 0, m_skip = 1;

    typedef struct {
        string      tag;
        logic [4:0] st;   // {l, fn, fz, fv, skip}
    } sb_t;
    sb_t sb_q[$];

    flag_unit #(.WIDTH(16), .FLAG_MSB(15)) dut (
        .clk5(clk5), .reset(reset), .y(y), .a15(a15), .b15(b15),
        .alu_l_toggle(alu_l_toggle), .alu_l_latch(alu_l_latch),
        .flagop(flagop), .ibus_in(ibus_in), .ibus_out(ibus_out),
        .ibus_oe(ibus_oe), .cond_en(cond_en), .cond_mask(cond_mask),
        .cond_inv(cond_inv), .l(l), .fn(fn), .fz(fz), .fv(fv), .skip(skip)
    );

    always #5 clk5 = ~clk5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] exp);
        check({tag, ".l"},    l,    exp[4]);
        check({tag, ".fn"},   fn,   exp[3]);
        check({tag, ".fz"},   fz,   exp[2]);
        check({tag, ".fv"},   fv,   exp[1]);
        check({tag, ".skip"}, skip, exp[0]);
    endtask

    // One clocked step using the currently driven inputs: bus checked combinationally
    // before the edge, expected post-edge state pushed, then popped and compared.
    task automatic step(input string tag);
        logic n_l, n_fn, n_fz, n_fv, n_skip, hit;
        sb_t  e;
        @(negedge clk5);
        #1;
        check({tag, ".oe"},  ibus_oe,  (flagop == 3'b110) ? 1'b0 : 1'b1);
        check({tag, ".bus"}, ibus_out, (flagop == 3'b110) ? {m_fn, m_l, m_fz, m_fv, 12'h000} : 16'h0000);

        n_l = m_l; n_fn = m_fn; n_fz = m_fz; n_fv = m_fv; n_skip = m_skip;
        if (flagop == 3'b001) begin
            n_fn = y[15];
            n_fz = (y == 16'h0000);
            n_fv = (a15 == b15) && (y[15] != a15);
        end
        if (flagop == 3'b101) begin
            n_fn = ibus_in[15]; n_l = ibus_in[14]; n_fz = ibus_in[13]; n_fv = ibus_in[12];
        end else if (flagop == 3'b010) n_l = 1'b0;
        else if (flagop == 3'b011) n_l = 1'b1;
        else if (flagop == 3'b100) n_l = !m_l;
        else if (alu_l_latch == 1'b0) n_l = alu_l_toggle;
        if (cond_en) begin
            hit = (cond_mask[3] & m_fn) | (cond_mask[2] & m_fz) |
                  (cond_mask[1] & m_fv) | (cond_mask[0] & m_l);
            n_skip = !(hit ^ cond_inv);
        end
        m_l = n_l; m_fn = n_fn; m_fz = n_fz; m_fv = n_fv; m_skip = n_skip;
        sb_q.push_back('{tag: tag, st: {n_l, n_fn, n_fz, n_fv, n_skip}});

        @(posedge clk5);
        #1;
        e = sb_q.pop_front();
        check_outputs(e.tag, e.st);
    endtask

    task automatic set_ops(input logic [2:0] op, input logic lat, input logic tog);
        flagop = op; alu_l_latch = lat; alu_l_toggle = tog;
    endtask

    task automatic set_cond(input logic en, input logic [3:0] mask, input logic inv);
        cond_en = en; cond_mask = mask; cond_inv = inv;
    endtask

    initial begin
        // Reset held low with random stimulus, including RDF on the bus
        for (int i = 0; i < 4; i++) begin
            @(negedge clk5);
            y = 16'($urandom); a15 = 1'($urandom); b15 = 1'($urandom);
            alu_l_toggle = 1'($urandom); alu_l_latch = 1'($urandom);
            flagop = (i == 0) ? 3'b110 : 3'($urandom);
            ibus_in = 16'($urandom);
            set_cond(1'($urandom), 4'($urandom), 1'($urandom));
            @(posedge clk5);
            #1;
            check_outputs("rst_hold", 5'b00001);
            check("rst_hold.oe",  ibus_oe,  1'b1);
            check("rst_hold.bus", ibus_out, 16'h0000);
        end

        @(negedge clk5);
        reset = 1'b1;
        set_cond(1'b0, 4'h0, 1'b0);
        ibus_in = '0;

        // ADD completions: UPD together with carry load
        y = 16'h8000; a15 = 0; b15 = 0; set_ops(3'b001, 1'b0, 1'b0);
        step("add_ovf");
        y = 16'h0000; a15 = 1; b15 = 1; set_ops(3'b001, 1'b0, 1'b1);
        step("add_zero");
        y = 16'h1234; a15 = 0; b15 = 1; set_ops(3'b001, 1'b1, 1'b0);
        step("upd_plain");

        // L ops and priority over the carry load
        set_ops(3'b011, 1'b1, 1'b0); step("stl");
        set_ops(3'b100, 1'b1, 1'b0); step("cml0");
        set_ops(3'b100, 1'b1, 1'b0); step("cml1");
        set_ops(3'b010, 1'b0, 1'b1); step("cll_prio");
        set_ops(3'b100, 1'b0, 1'b0); step("cml_prio");
        set_ops(3'b000, 1'b0, 1'b0); step("latch_only");
        set_ops(3'b111, 1'b1, 1'b1); step("reserved");

        // Save / restore
        ibus_in = 16'hA000; set_ops(3'b101, 1'b0, 1'b1); step("wrf_a000");
        ibus_in = 16'h0000; set_ops(3'b110, 1'b1, 1'b0); step("rdf");
        set_ops(3'b000, 1'b1, 1'b0); step("idle_bus");

        // Skip condition
        ibus_in = 16'h2000; set_ops(3'b101, 1'b1, 1'b0); step("wrf_z");
        set_ops(3'b000, 1'b1, 1'b0);
        set_cond(1'b1, 4'b0100, 1'b0); step("skip_z");
        set_cond(1'b1, 4'b0001, 1'b0); step("skip_l");
        set_cond(1'b1, 4'b0100, 1'b0); step("skip_z2");
        set_cond(1'b0, 4'b0001, 1'b1);
        y = 16'h0001; a15 = 0; b15 = 0; set_ops(3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("skip_hold");
        ibus_in = 16'h2000; set_ops(3'b101, 1'b1, 1'b0); step("wrf_z2");
        y = 16'h0001; set_ops(3'b001, 1'b1, 1'b0);
        set_cond(1'b1, 4'b0100, 1'b0); step("skip_old_z");
        set_ops(3'b000, 1'b1, 1'b0);
        set_cond(1'b1, 4'b0000, 1'b0); step("skip_never");
        set_cond(1'b1, 4'b0000, 1'b1); step("skip_always");
        set_cond(1'b1, 4'b1000, 1'b1); step("skip_inv");
        set_cond(1'b0, 4'b0000, 1'b0);

        // Reset asserted in the middle of a WRF cycle
        ibus_in = 16'hF000; set_ops(3'b101, 1'b1, 1'b0); step("wrf_f000");
        ibus_in = 16'h5000;
        @(negedge clk5);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("rst_async", 5'b00001);
        @(posedge clk5);
        #1;
        check_outputs("rst_edge", 5'b00001);
        @(negedge clk5);
        reset = 1'b1;
        m_l = 0; m_fn = 0; m_fz = 0; m_fv = 0; m_skip = 1;
        step("wrf_after_rst");

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
